// File: rtl/fp_add_arbiter.sv
// Round-robin scheduler that time-shares one combinational double-precision adder
// among NUM_REQ requesters, returning tagged results on a single response channel.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [64*NUM_REQ-1:0]  req_a,
  input  logic [64*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  output logic [63:0]            add_a,
  output logic [63:0]            add_b,
  input  logic [63:0]            add_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [63:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_nan,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic [63:0]     sel_a;
  logic [63:0]     sel_b;
  logic            sel_sub;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_sub     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
        sel_a       = req_a[64*j +: 64];
        sel_b       = req_b[64*j +: 64];
        sel_sub     = req_sub[j];
      end
    end
  end

  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign req_ready = (state == IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_nan   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_a   <= sel_a;
            add_b   <= {sel_b[63] ^ sel_sub, sel_b[62:0]};
            resp_id <= grant_idx;
            rr_ptr  <= next_ptr;
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= add_result;
          resp_nan   <= (add_result[62:52] == 11'h7FF) && (add_result[51:0] != 52'd0);
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // Results wait here under backpressure; no new grant until released.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
